// File: rtl/game_state_regs_if.sv
// rtl/game_state_regs_if.sv - load/readback bus between the game FSM and its register file
interface game_state_regs_if;
    logic       Load_S;
    logic       Load_F;
    logic       Load_L;
    logic [9:0] score_to_reg;
    logic [3:0] fruits_to_reg;
    logic [7:0] lives_to_reg;
    logic [9:0] score_from_reg;
    logic [3:0] fruits_from_reg;
    logic [7:0] lives_from_reg;

    modport master (
        output Load_S, Load_F, Load_L, score_to_reg, fruits_to_reg, lives_to_reg,
        input  score_from_reg, fruits_from_reg, lives_from_reg
    );

    modport slave (
        input  Load_S, Load_F, Load_L, score_to_reg, fruits_to_reg, lives_to_reg,
        output score_from_reg, fruits_from_reg, lives_from_reg
    );
endinterface

// File: rtl/game_state_regs.sv
// rtl/game_state_regs.sv - score/fruit/lives registers, round timer and dot counter for the game FSM
// Optional high-score register enabled by defining GAME_HISCORE_EN.
module game_state_regs #(
    parameter int DOT_TOTAL     = 244,
    parameter int TIME_INIT     = 120,
    parameter int TICKS_PER_SEC = 60,
    parameter int DOT_POINTS    = 10
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               restart,
    input  logic               pause,
    input  logic               frame_tick,
    input  logic               dot_eaten,
    game_state_regs_if.slave   regs,
    output logic [31:0]        counter,
    output logic [31:0]        dots_left,
    output logic [9:0]         hi_score
);

    localparam logic [31:0] COUNTER_INIT = 32'(TIME_INIT);
    localparam logic [31:0] DOTS_INIT    = 32'(DOT_TOTAL - 1);
    localparam logic [6:0]  PRESC_LAST   = 7'(TICKS_PER_SEC - 1);
    localparam logic [10:0] DOT_ADD      = 11'(DOT_POINTS);

    logic [6:0]  prescaler;
    logic        dot_hit;
    logic        tick_hit;
    logic [9:0]  score_base;
    logic [10:0] score_sum;
    logic [9:0]  score_next;

    assign dot_hit  = dot_eaten & ~pause;
    assign tick_hit = frame_tick & ~pause;

    // Sum one bit wider than the score so overflow saturates instead of wrapping.
    always_comb begin
        score_base = regs.Load_S ? regs.score_to_reg : regs.score_from_reg;
        score_sum  = {1'b0, score_base} + (dot_hit ? DOT_ADD : 11'd0);
        score_next = score_sum[10] ? 10'h3FF : score_sum[9:0];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            regs.score_from_reg  <= '0;
            regs.fruits_from_reg <= '0;
            regs.lives_from_reg  <= '0;
        end else if (restart) begin
            regs.score_from_reg  <= '0;
            regs.fruits_from_reg <= '0;
            regs.lives_from_reg  <= '0;
        end else begin
            regs.score_from_reg <= score_next;
            if (regs.Load_F) regs.fruits_from_reg <= regs.fruits_to_reg;
            if (regs.Load_L) regs.lives_from_reg  <= regs.lives_to_reg;
        end
    end

    // All-ones is the "every dot eaten" marker and is sticky until restart.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dots_left <= DOTS_INIT;
        end else if (restart) begin
            dots_left <= DOTS_INIT;
        end else if (dot_hit && (dots_left != 32'hFFFF_FFFF)) begin
            dots_left <= dots_left - 32'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prescaler <= '0;
            counter   <= COUNTER_INIT;
        end else if (restart) begin
            prescaler <= '0;
            counter   <= COUNTER_INIT;
        end else if (tick_hit) begin
            if (prescaler == PRESC_LAST) begin
                prescaler <= '0;
                if (counter != 32'd0) counter <= counter - 32'd1;
            end else begin
                prescaler <= prescaler + 7'd1;
            end
        end
    end

`ifdef GAME_HISCORE_EN
    // Tracks the incoming score value so the best score lands in the same cycle as the write.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hi_score <= '0;
        end else if (!restart && (score_next > hi_score)) begin
            hi_score <= score_next;
        end
    end
`else
    assign hi_score = 10'd0;
`endif

endmodule
